dsp_fetch: RTL and testbench

//  Instruction-fetch stage feeding DSPDecode: owns the PC and drives a synchronous-read instruction memory.

---
 rtl/dsp_fetch_pkg.sv | 11 +
 rtl/dsp_fetch_skid.sv | 51 +++++
 rtl/dsp_fetch.sv | 110 +++++++++++
 tb/tb_dsp_fetch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dsp_fetch_pkg.sv
// Shared widths and constants for the instruction-fetch stage.
package dsp_fetch_pkg;

  localparam int unsigned MEM_ADDR_LEN  = 16;
  localparam int unsigned INST_WORD_LEN = 32;

  // Opcode 6'b111111 decodes as NOP: no writeback, no memory access, no flow change.
  localparam logic [INST_WORD_LEN-1:0] INST_NOP = 32'hFC00_0000;
  localparam logic [MEM_ADDR_LEN-1:0]  RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/dsp_fetch_skid.sv
// One-entry {inst, pc} holding buffer that catches the in-flight fetch
// response when the pipeline stalls.
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   i_load            capture i_inst/i_pc and set valid
//   i_drain           entry consumed by IF/ID; clear valid
//   i_clear           discard entry (redirect)
//   i_inst, i_pc      word and address to capture
//   o_valid           entry holds a word
//   o_inst, o_pc      buffered word and address
module dsp_fetch_skid
  import dsp_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_drain,
  input  logic                     i_clear,
  input  logic [INST_WORD_LEN-1:0] i_inst,
  input  logic [MEM_ADDR_LEN-1:0]  i_pc,
  output logic                     o_valid,
  output logic [INST_WORD_LEN-1:0] o_inst,
  output logic [MEM_ADDR_LEN-1:0]  o_pc
);

  logic                     r_valid;
  logic [INST_WORD_LEN-1:0] r_inst;
  logic [MEM_ADDR_LEN-1:0]  r_pc;

  // Clear beats load beats drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= INST_NOP;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/dsp_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read
// instruction memory and registers the fetched word into IF/ID.
// Predict-not-taken; execute-stage redirects flush the in-flight word.
// Ports:
//   clk, rst                 pipeline clock, synchronous active-high reset
//   stall                    hold IF/ID and PC, no new fetch
//   redirect_valid/_addr     taken branch/jump target from execute
//   imem_rd_en/imem_addr     memory read strobe/address (combinational)
//   imem_rdata               read data, valid one cycle after imem_rd_en
//   inst_out/pc_out          IF/ID instruction and its address
//   inst_valid               inst_out is a real instruction (0 = bubble)
module dsp_fetch
  import dsp_fetch_pkg::*;
#(
  parameter logic [MEM_ADDR_LEN-1:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_WORD_LEN-1:0] NOP_INST = INST_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [MEM_ADDR_LEN-1:0]  redirect_addr,
  output logic                     imem_rd_en,
  output logic [MEM_ADDR_LEN-1:0]  imem_addr,
  input  logic [INST_WORD_LEN-1:0] imem_rdata,
  output logic [INST_WORD_LEN-1:0] inst_out,
  output logic [MEM_ADDR_LEN-1:0]  pc_out,
  output logic                     inst_valid
);

  logic [MEM_ADDR_LEN-1:0]  r_pc;
  logic [MEM_ADDR_LEN-1:0]  r_req_pc;
  logic                     r_req_valid;
  logic [INST_WORD_LEN-1:0] r_inst;
  logic [MEM_ADDR_LEN-1:0]  r_pc_out;
  logic                     r_inst_valid;

  logic                     w_issue;
  logic                     w_skid_load;
  logic                     w_skid_drain;
  logic                     w_skid_valid;
  logic [INST_WORD_LEN-1:0] w_skid_inst;
  logic [MEM_ADDR_LEN-1:0]  w_skid_pc;

  // A redirect fetches even while stalled so the target is already in flight.
  assign w_issue    = !rst && (redirect_valid || !stall);
  assign imem_rd_en = w_issue;
  assign imem_addr  = redirect_valid ? redirect_addr : r_pc;

  // Only one fetch can be outstanding when a stall starts, so loading
  // solely into an empty skid never loses a word.
  assign w_skid_load  = !redirect_valid && stall && r_req_valid && !w_skid_valid;
  assign w_skid_drain = !redirect_valid && !stall && w_skid_valid;

  dsp_fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (redirect_valid),
    .i_inst  (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_skid_valid),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  // PC, outstanding-request tracking and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= '0;
      r_req_valid  <= 1'b0;
      r_inst       <= NOP_INST;
      r_pc_out     <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pc        <= imem_addr + MEM_ADDR_LEN'(1);
        r_req_pc    <= imem_addr;
        r_req_valid <= 1'b1;
      end else begin
        r_req_valid <= 1'b0;
      end

      if (redirect_valid) begin
        r_inst       <= NOP_INST;
        r_inst_valid <= 1'b0;
      end else if (!stall) begin
        if (w_skid_valid) begin
          r_inst       <= w_skid_inst;
          r_pc_out     <= w_skid_pc;
          r_inst_valid <= 1'b1;
        end else if (r_req_valid) begin
          r_inst       <= imem_rdata;
          r_pc_out     <= r_req_pc;
          r_inst_valid <= 1'b1;
        end else begin
          r_inst       <= NOP_INST;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  assign inst_out   = r_inst;
  assign pc_out     = r_pc_out;
  assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_dsp_fetch.sv
// Directed bench for dsp_fetch. Instruction memory holds mem[i] = i.
module tb_dsp_fetch;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [15:0] pc_out;
  logic        inst_valid;

  int n_total = 0;
  int n_pass  = 0;

  dsp_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, contents equal to the address.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'(imem_addr);
  end

  typedef struct {
    logic        stall;
    logic        rv;
    logic [15:0] raddr;
    logic        ev;
    logic [15:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic rv, input logic [15:0] a,
                     input logic ev, input logic [15:0] pc);
    vec_t v;
    v.stall = s; v.rv = rv; v.raddr = a; v.ev = ev; v.epc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] a);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;

    // Sequential run, redirect, stall with skid, redirects, pc wrap.
    add(0,0,16'h0000, 0,16'h0000);   // 0: first fetch issued, bubble
    add(0,0,16'h0000, 1,16'h0000);   // 1: RESET_PC word, 2 cycles after release
    add(0,0,16'h0000, 1,16'h0001);
    add(0,0,16'h0000, 1,16'h0002);
    add(0,0,16'h0000, 1,16'h0003);   // 4: 0x0004 in flight
    add(0,1,16'h0010, 0,16'h0000);   // 5: redirect, 0x0004 dropped
    add(0,0,16'h0000, 1,16'h0010);   // 6: target, 0x11 in flight
    add(1,0,16'h0000, 1,16'h0010);   // 7: stall, 0x11 into skid
    add(1,0,16'h0000, 1,16'h0010);
    add(1,0,16'h0000, 1,16'h0010);
    add(0,0,16'h0000, 1,16'h0011);   // 10: skid word, no bubble
    add(0,0,16'h0000, 1,16'h0012);
    add(0,0,16'h0000, 1,16'h0013);   // 12: 0x14 in flight
    add(0,1,16'h0040, 0,16'h0000);   // 13: redirect drops 0x14
    add(0,0,16'h0000, 1,16'h0040);
    add(0,0,16'h0000, 1,16'h0041);
    add(1,0,16'h0000, 1,16'h0041);   // 16: skid = 0x42
    add(1,0,16'h0000, 1,16'h0041);
    add(1,1,16'h0080, 0,16'h0000);   // 18: redirect while held, skid dropped
    add(0,0,16'h0000, 1,16'h0080);
    add(0,0,16'h0000, 1,16'h0081);
    add(0,0,16'h0000, 1,16'h0082);
    add(1,1,16'h0090, 0,16'h0000);   // 22: redirect under a continuing stall
    add(1,0,16'h0000, 0,16'h0000);   // 23: bubble held, 0x90 into skid
    add(0,0,16'h0000, 1,16'h0090);
    add(0,0,16'h0000, 1,16'h0091);
    add(0,1,16'hFFFE, 0,16'h0000);   // 26: jump near top of address space
    add(0,0,16'h0000, 1,16'hFFFE);
    add(0,0,16'h0000, 1,16'hFFFF);
    add(0,0,16'h0000, 1,16'h0000);   // 29: pc wrapped
    add(0,0,16'h0000, 1,16'h0001);

    // Reset state.
    step(1, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0000);
    chk("reset_rd_en", 32'(imem_rd_en), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst",  inst_out, NOP);
    chk("reset_pc",    32'(pc_out), 32'd0);

    foreach (vecs[i]) begin
      step(0, vecs[i].stall, vecs[i].rv, vecs[i].raddr);
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_inst", i), inst_out, vecs[i].ev ? 32'(vecs[i].epc) : NOP);
      if (vecs[i].ev) chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vecs[i].epc));
    end

    // Reset asserted while stalled with the skid full.
    step(0, 1, 0, 16'h0000);         // 0x0002 into skid
    chk("held_inst", inst_out, 32'h0000_0001);
    @(negedge clk);
    rst = 1'b1; stall = 1'b1;
    #1;
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(inst_valid), 32'd0);
    chk("rst_mid_inst",  inst_out, NOP);
    chk("rst_mid_pc",    32'(pc_out), 32'd0);
    step(0, 0, 0, 16'h0000);
    chk("refetch_bubble", 32'(inst_valid), 32'd0);
    step(0, 0, 0, 16'h0000);
    chk("refetch0_valid", 32'(inst_valid), 32'd1);
    chk("refetch0_inst",  inst_out, 32'h0000_0000);
    chk("refetch0_pc",    32'(pc_out), 32'd0);
    step(0, 0, 0, 16'h0000);
    chk("refetch1_inst",  inst_out, 32'h0000_0001);
    chk("refetch1_pc",    32'(pc_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
